// File: rtl/ad_ip_jesd204_tpl_dac_pn_gen.sv
// ad_ip_jesd204_tpl_dac_pn_gen: per-channel DAC test-pattern source (PN7/9/15/23/31, ramp, zero, DMA pass-through)
module ad_ip_jesd204_tpl_dac_pn_gen #(
  parameter int DATA_PATH_WIDTH = 4,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                                    link_clk,
  input  logic                                    dac_rst,
  input  logic [3:0]                              pn_seq_sel,
  input  logic                                    enable,
  input  logic                                    sync,
  input  logic                                    tx_ready,
  input  logic [DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0] dma_data,
  output logic                                    dma_rd,
  output logic [DATA_PATH_WIDTH*SAMPLE_WIDTH-1:0] tx_data
);
  localparam int W = DATA_PATH_WIDTH * SAMPLE_WIDTH;
  localparam int PN_N [5] = '{7, 15, 9, 23, 31};
  localparam int PN_T [5] = '{6, 14, 5, 18, 28};
  localparam logic [31:0] SEED = 32'hFFFF_FFFF;
  // Bits above the LFSR length are never tapped, so the state is left unmasked.
  function automatic logic [W+31:0] pn_step(input logic [31:0] seed, input int n, input int t);
    logic [31:0] s;
    logic [W-1:0] d;
    logic [W-1:0] o;
    logic b;
    s = seed;
    d = '0;
    o = '0;
    for (int j = 0; j < W; j++) begin
      b = s[5'(n - 1)] ^ s[5'(t - 1)];
      s = {s[30:0], b};
      d = {d[W-2:0], b};
    end
    for (int k = 0; k < DATA_PATH_WIDTH; k++)
      o[SAMPLE_WIDTH*k +: SAMPLE_WIDTH] = d[W-1-SAMPLE_WIDTH*k -: SAMPLE_WIDTH];
    return {s, o};
  endfunction
  logic [W-1:0] tx_data_q, tx_data_d;
  logic [3:0] sel_q;
  logic [15:0] base_q, base_d, base_cur;
  logic [31:0] lfsr_q [5];
  logic [31:0] lfsr_d [5];
  logic [W-1:0] pn_word [5];
  logic [W-1:0] ramp, pat;
  logic [W+31:0] step;
  logic restart, adv;
  assign adv = tx_ready & enable;
  assign dma_rd = adv & (pn_seq_sel == 4'd0);
  assign tx_data = tx_data_q;
  always_comb begin
    restart = sync | (pn_seq_sel != sel_q);
    base_cur = restart ? 16'd0 : base_q;
    base_d = adv ? base_cur + 16'(DATA_PATH_WIDTH) : base_cur;
    step = '0;
    ramp = '0;
    for (int i = 0; i < 5; i++) begin
      step = pn_step(restart ? SEED : lfsr_q[i], PN_N[i], PN_T[i]);
      pn_word[i] = step[W-1:0];
      lfsr_d[i] = adv ? step[W +: 32] : (restart ? SEED : lfsr_q[i]);
    end
    for (int k = 0; k < DATA_PATH_WIDTH; k++)
      ramp[SAMPLE_WIDTH*k +: SAMPLE_WIDTH] = SAMPLE_WIDTH'(base_cur + 16'(k));
    pat = '0;
    case (pn_seq_sel)
      4'd0: pat = dma_data;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: pat = pn_word[3'(pn_seq_sel - 4'd1)];
      4'd6: pat = ramp;
      default: pat = '0;
    endcase
    tx_data_d = !enable ? '0 : adv ? pat : tx_data_q;
  end
  always_ff @(posedge link_clk or posedge dac_rst) begin
    if (dac_rst) begin
      tx_data_q <= '0;
      sel_q <= '0;
      base_q <= '0;
      lfsr_q <= '{default: SEED};
    end else begin
      tx_data_q <= tx_data_d;
      sel_q <= pn_seq_sel;
      base_q <= base_d;
      lfsr_q <= lfsr_d;
    end
  end
endmodule
